// File: rtl/timer_pkg.sv
// timer_pkg: shared cycle defaults, event indices and counter sizing for the timer button path
// No ports; imported by timer_btn_ctrl.
package timer_pkg;
   localparam int DEBOUNCE_CYC     = 20;
   localparam int REPEAT_DELAY_CYC = 500;
   localparam int REPEAT_CYC       = 100;
   localparam int LONG_CYC         = 1000;
   // Bit positions in the pending/pulse vectors; lower index wins arbitration.
   localparam int EV_CLEAR = 0;
   localparam int EV_RESET = 1;
   localparam int EV_START = 2;
   localparam int EV_MIN   = 3;
   localparam int EV_SEC   = 4;
   localparam int NUM_EV   = 5;
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a > b ? a : b;
      m = m > c ? m : c;
      return $clog2(m + 1);
   endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchroniser and debouncer for one raw button, flags accepted level changes
// clk, rst : clock, asynchronous active-high reset
// btn_i    : raw asynchronous button
// db_o     : debounced level
// chg_o    : db_o changes at this edge (rises suppressed until the button is seen released after reset)
module btn_debounce #(
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE_CYC = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic db_o,
   output logic chg_o
);
   localparam int CW = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
   logic [SYNC_STAGES-1:0] sync_q, vld_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic db_q, db_d, arm_q, arm_d, synced, hit;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         vld_q  <= '0;
         cnt_q  <= '0;
         db_q   <= 1'b0;
         arm_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
         vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
         cnt_q  <= cnt_d;
         db_q   <= db_d;
         arm_q  <= arm_d;
      end
   end
   always_comb begin
      synced = sync_q[SYNC_STAGES-1];
      hit    = synced != db_q && cnt_q == CNT_LAST;
      cnt_d  = (synced == db_q || hit) ? '0 : cnt_q + 1'b1;
      db_d   = hit ? synced : db_q;
      // A button held through reset must be seen released (once the synchroniser
      // holds real samples) before its next rise counts as a press.
      arm_d  = arm_q | (vld_q[SYNC_STAGES-1] & ~synced);
      chg_o  = hit && (arm_q || db_q);
   end
   assign db_o = db_q;
endmodule

// File: rtl/timer_btn_ctrl.sv
// timer_btn_ctrl: conditions the four timer buttons into arbitrated one-cycle command pulses
// clk, rst       : 1 kHz clock, asynchronous active-high reset
// timer_mode     : block active; low clears pending work and holds outputs at 0
// btn_min/sec/start/reset : raw asynchronous active-high buttons
// min_set_p, sec_set_p, start_stop_p, reset_p, clear_set_p : registered command pulses
module timer_btn_ctrl import timer_pkg::*; #(
   parameter int SYNC_STAGES      = 2,
   parameter int DEBOUNCE_CYC     = timer_pkg::DEBOUNCE_CYC,
   parameter int REPEAT_DELAY_CYC = timer_pkg::REPEAT_DELAY_CYC,
   parameter int REPEAT_CYC       = timer_pkg::REPEAT_CYC,
   parameter int LONG_CYC         = timer_pkg::LONG_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic timer_mode,
   input  logic btn_min,
   input  logic btn_sec,
   input  logic btn_start,
   input  logic btn_reset,
   output logic min_set_p,
   output logic sec_set_p,
   output logic start_stop_p,
   output logic reset_p,
   output logic clear_set_p
);
   localparam int CW = cnt_width(LONG_CYC, REPEAT_DELAY_CYC, DEBOUNCE_CYC);
   localparam logic [CW-1:0] RD_LAST   = CW'(REPEAT_DELAY_CYC - 1);
   localparam logic [CW-1:0] RD_RELOAD = CW'(REPEAT_DELAY_CYC - REPEAT_CYC);
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
   localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_CYC);
   // Button order: 0 min, 1 sec, 2 start, 3 reset.
   logic [3:0] btn, db, chg, rise;
   logic [1:0] rep_act_q, rep_act_d, rep_ev;
   logic [1:0][CW-1:0] rep_cnt_q, rep_cnt_d;
   logic lp_act_q, lp_act_d, lp_long, lp_short;
   logic [CW-1:0] lp_cnt_q, lp_cnt_d;
   logic [NUM_EV-1:0] set, grant, pend_q, pend_d, pulse_q, pulse_d;
   assign btn = {btn_reset, btn_start, btn_sec, btn_min};
   for (genvar i = 0; i < 4; i++) begin : g_db
      btn_debounce #(
         .SYNC_STAGES (SYNC_STAGES),
         .DEBOUNCE_CYC(DEBOUNCE_CYC)
      ) u_db (
         .clk  (clk),
         .rst  (rst),
         .btn_i(btn[i]),
         .db_o (db[i]),
         .chg_o(chg[i])
      );
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_act_q <= '0;
         rep_cnt_q <= '0;
         lp_act_q  <= 1'b0;
         lp_cnt_q  <= '0;
         pend_q    <= '0;
         pulse_q   <= '0;
      end else begin
         rep_act_q <= rep_act_d;
         rep_cnt_q <= rep_cnt_d;
         lp_act_q  <= lp_act_d;
         lp_cnt_q  <= lp_cnt_d;
         pend_q    <= pend_d;
         pulse_q   <= pulse_d;
      end
   end
   always_comb begin
      rise = chg & ~db;
      // Repeat counter restarts at the rise; after each repeat it reloads so the
      // next one lands REPEAT_CYC later, independent of when pulses were granted.
      for (int k = 0; k < 2; k++) begin
         rep_ev[k]    = rep_act_q[k] && !(chg[k] && db[k]) && rep_cnt_q[k] == RD_LAST;
         rep_act_d[k] = timer_mode && (rise[k] || (rep_act_q[k] && !(chg[k] && db[k])));
         rep_cnt_d[k] = (!rep_act_d[k] || rise[k]) ? '0 : rep_ev[k] ? RD_RELOAD : rep_cnt_q[k] + 1'b1;
      end
      // Reset hold counter saturates at LONG_MAX, which doubles as the "clear already issued" mark.
      lp_long  = lp_act_q && !(chg[3] && db[3]) && lp_cnt_q == LONG_LAST;
      lp_short = lp_act_q && chg[3] && db[3] && lp_cnt_q != LONG_MAX;
      lp_act_d = timer_mode && (rise[3] || (lp_act_q && !(chg[3] && db[3])));
      lp_cnt_d = (!lp_act_d || rise[3]) ? '0 : lp_cnt_q == LONG_MAX ? lp_cnt_q : lp_cnt_q + 1'b1;
      set = '0;
      set[EV_CLEAR] = lp_long;
      set[EV_RESET] = lp_short;
      set[EV_START] = rise[2];
      set[EV_MIN]   = rise[0] | rep_ev[0];
      set[EV_SEC]   = rise[1] | rep_ev[1];
      // Lowest set bit is the highest-priority pending event.
      grant   = pend_q & (~pend_q + 1'b1);
      pend_d  = timer_mode ? (pend_q | set) & ~grant : '0;
      pulse_d = timer_mode ? grant : '0;
   end
   assign clear_set_p  = pulse_q[EV_CLEAR];
   assign reset_p      = pulse_q[EV_RESET];
   assign start_stop_p = pulse_q[EV_START];
   assign min_set_p    = pulse_q[EV_MIN];
   assign sec_set_p    = pulse_q[EV_SEC];
endmodule

// File: doc/timer_btn_ctrl.md
# timer_btn_ctrl

Conditions the four raw push-buttons of the countdown-timer mode and produces the single-cycle command pulses consumed directly by `timer_core` (`min_set_p`, `sec_set_p`, `start_stop_p`, `reset_p`, `clear_set_p`). It synchronises, debounces, edge-detects and arbitrates the buttons, adds auto-repeat on the set buttons, and derives clear from a long press of reset. It runs on the same 1 kHz `clk` as `timer_core`, so one cycle is 1 ms.

## Interface
- `SYNC_STAGES`, 2: synchroniser flops per button (≥2)
- `DEBOUNCE_CYC`, 20: consecutive stable cycles required to accept a level change
- `REPEAT_DELAY_CYC`, 500: hold time before the first auto-repeat pulse (min/sec only)
- `REPEAT_CYC`, 100: auto-repeat period after the first repeat (< `REPEAT_DELAY_CYC`)
- `LONG_CYC`, 1000: reset hold time that converts to clear
- `clk`  in  1  system clock, 1 kHz
- `rst`  in  1  asynchronous, active-high reset
- `timer_mode`  in  1  timer mode active; low = block idle
- `btn_min`, `btn_sec`, `btn_start`, `btn_reset`  in  1 each  raw, asynchronous, active-high buttons
- `min_set_p`, `sec_set_p`, `start_stop_p`, `reset_p`, `clear_set_p`  out  1 each  registered one-cycle command pulses

## Operation
- Per button: `SYNC_STAGES`-flop synchroniser, then a debouncer. The debounced level `db` takes the synced value once that value has differed from `db` for `DEBOUNCE_CYC` consecutive cycles. The counter clears whenever the synced value equals `db`. A rise event is flagged when `db` goes 0→1; a fall event when it goes 1→0.
- Debouncers run regardless of `timer_mode`. A button already held when `timer_mode` rises produces no event.
- **start:** a rise event sets `pend_start`.
- **min / sec:** a rise event sets the pending bit and starts that button's hold counter.
  - While `db` stays high: the first repeat fires at `REPEAT_DELAY_CYC` cycles after the rise, then one every `REPEAT_CYC` cycles. Each repeat sets the pending bit.
  - A fall stops repeating and clears the counter.
- **reset:** a rise starts a hold counter, which saturates at `LONG_CYC`.
  - When the counter reaches `LONG_CYC` while held, `pend_clear` is set exactly once.
  - On the fall event, `pend_reset` is set only if `LONG_CYC` was not reached. A long press therefore yields clear only, never reset.
- **Arbiter:** at most one output pulse per cycle. Fixed priority clear > reset > start > min > sec. The granted pending bit clears in the cycle its pulse is driven. Non-granted bits stay pending and are emitted in later cycles in priority order. A new event on an already-pending button is merged (no double pulse).
- **`timer_mode` low:** outputs 0, all pending bits and hold/repeat counters cleared. Debounced levels are kept.

## Timing
- Reset values: all outputs 0, all synchronisers, `db`, counters and pending bits 0.
- Latency, press or release:
  - Raw change sampled at edge 0 → `db` updates at edge `SYNC_STAGES + DEBOUNCE_CYC − 1`.
  - Pending bit set at the same edge.
  - Pulse high for the following cycle if ungranted competition is absent, i.e. `L = SYNC_STAGES + DEBOUNCE_CYC` edges (22 with defaults).
- Repeat pulses land exactly `REPEAT_DELAY_CYC`, `+REPEAT_CYC`, … after the initial pulse, unless delayed by arbitration. Delays do not accumulate: the repeat schedule is counter-based.
- Counter width is `$clog2(max(LONG_CYC, REPEAT_DELAY_CYC, DEBOUNCE_CYC) + 1)`. Counters saturate and never wrap.
- `rst` mid-hold: all state cleared asynchronously. A button still held after release of `rst` produces no event until it is released and pressed again.
- `timer_mode` falling in the same cycle as a pending grant: mode wins, no pulse.

## Structure
- Shared `timer_pkg`:
  - default cycle constants (`DEBOUNCE_CYC`, `REPEAT_DELAY_CYC`, `REPEAT_CYC`, `LONG_CYC`)
  - event index localparams (`EV_CLEAR`, `EV_RESET`, `EV_START`, `EV_MIN`, `EV_SEC`) for the pending vector and priority encoder
- One sub-module, `btn_debounce`, instantiated four times. It contains the synchroniser, debouncer and rise/fall flags (params `SYNC_STAGES`, `DEBOUNCE_CYC`).
- Hold/repeat logic, pending vector and arbiter live in the top module.

## Test plan
- **Clean min press:** `btn_min` high 200 cycles → exactly one `min_set_p`, 22 cycles after the press; no other outputs.
- **Bounce:** `btn_start` toggling with 5-cycle pulses for 100 cycles, then low → no `start_stop_p`. A 5-cycle glitch then a steady 50-cycle press → one pulse, 22 cycles after the steady edge.
- **Auto-repeat:** `btn_sec` held 1450 cycles after `db` rise at T → `sec_set_p` at T+1, T+501, T+601, …, T+1401. That is 11 pulses; none after release.
- **Reset short vs long:**
  - held 300 cycles → one `reset_p` 22 cycles after release, no `clear_set_p`.
  - held 1500 cycles → one `clear_set_p` at `db` rise + 1000 + 1, no `reset_p` on release.
- **Simultaneous:** `btn_min` and `btn_start` rise in the same cycle → `start_stop_p` in cycle N, `min_set_p` in cycle N+1, never both high together.
- **Mode / reset interruption:**
  - `timer_mode` dropped at hold count 400 of `btn_min`, restored while still held → no further pulses until re-press.
  - `rst` asserted mid-hold → all outputs 0 immediately.
